// File: rtl/register_file_mips.sv
// ---------------------------------------------------------------------------
// register_file_mips
//
// MIPS-style register file with two combinational read ports, one write
// port, and a per-register "pending" (busy) scoreboard used for hazard
// stalls. Register 0 is hard-wired to zero.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a write in progress is forwarded to a read port addressing
//               the same register in the same cycle, and that port does not
//               contribute to stall.
//   undefined : read ports return the pre-write value during the write
//               cycle.
//
// Parameters
//   DATA_W    register width
//   NUM_REGS  register count (power of two, >= 2)
//   ADR_W     address width, must equal log2(NUM_REGS)
//
// Ports
//   clk                  rising-edge clock
//   rst_n                asynchronous active-low reset
//   regwrite             write enable for dst_adr / write_data
//   dst_adr, write_data  write address / data
//   read_adr1/2          read addresses
//   readout1/2           combinational read data
//   busy_set, busy_adr   mark busy_adr as pending
//   stall                a read port addresses a pending register
//   busy_vec             per-register pending flags (bit i = register i)
// ---------------------------------------------------------------------------
module register_file_mips #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADR_W    = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                regwrite,
    input  logic [ADR_W-1:0]    dst_adr,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [ADR_W-1:0]    read_adr1,
    input  logic [ADR_W-1:0]    read_adr2,
    output logic [DATA_W-1:0]   readout1,
    output logic [DATA_W-1:0]   readout2,
    input  logic                busy_set,
    input  logic [ADR_W-1:0]    busy_adr,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic                write_en;
    logic                hit1;
    logic                hit2;

    // Writes to register 0 are discarded everywhere by qualifying here.
    assign write_en = regwrite && (dst_adr != '0);

    // NOTE: the whole array sits inside the async reset because the
    // register file must read as zero immediately on reset; that rules out
    // mapping it onto a RAM macro without a clear port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every reader of regs and
            // busy_q in this edge seeing the pre-edge values.
            if (write_en) begin
                regs[dst_adr] <= write_data;
            end
            // Bit 0 is never touched after reset, so it stays constant 0.
            for (int i = 1; i < NUM_REGS; i++) begin
                if (busy_set && (busy_adr == ADR_W'(i))) begin
                    // A new producer supersedes one completing this cycle.
                    busy_q[i] <= 1'b1;
                end else if (write_en && (dst_adr == ADR_W'(i))) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign hit1 = write_en && (read_adr1 == dst_adr);
    assign hit2 = write_en && (read_adr2 == dst_adr);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    // Outputs are forced low while reset is held so a forwarded write_data
    // cannot leak out during reset.
    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        readout1 = '0;
        readout2 = '0;
        stall    = 1'b0;
        busy_vec = '0;
        if (rst_n) begin
            if (read_adr1 != '0) begin
                readout1 = hit1 ? write_data : regs[read_adr1];
            end
            if (read_adr2 != '0) begin
                readout2 = hit2 ? write_data : regs[read_adr2];
            end
            stall    = (busy_q[read_adr1] && !hit1) ||
                       (busy_q[read_adr2] && !hit2);
            busy_vec = busy_q;
        end
    end

endmodule

// File: tb/tb_register_file_mips.sv
// ---------------------------------------------------------------------------
// tb_register_file_mips
//
// Self-checking bench for register_file_mips. A behavioural model (plain
// arrays) predicts the combinational outputs for every driven cycle; the
// prediction is queued, and a monitor pops and compares on the falling
// edge. A second instance (DATA_W=16, NUM_REGS=8, ADR_W=3) gets a small
// write/read-back sweep through its own queue.
// ---------------------------------------------------------------------------
module tb_register_file_mips;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          regwrite = 1'b0;
    logic [AW-1:0] dst_adr = '0;
    logic [DW-1:0] write_data = '0;
    logic [AW-1:0] read_adr1 = '0;
    logic [AW-1:0] read_adr2 = '0;
    logic          busy_set = 1'b0;
    logic [AW-1:0] busy_adr = '0;
    logic [DW-1:0] readout1;
    logic [DW-1:0] readout2;
    logic          stall;
    logic [NR-1:0] busy_vec;

    // Small instance for the parameter sweep.
    logic          s_regwrite = 1'b0;
    logic [2:0]    s_dst_adr = '0;
    logic [15:0]   s_write_data = '0;
    logic [2:0]    s_read_adr1 = '0;
    logic [2:0]    s_read_adr2 = '0;
    logic          s_busy_set = 1'b0;
    logic [2:0]    s_busy_adr = '0;
    logic [15:0]   s_readout1;
    logic [15:0]   s_readout2;
    logic          s_stall;
    logic [7:0]    s_busy_vec;

    always #5 clk = ~clk;

    register_file_mips #(.DATA_W(DW), .NUM_REGS(NR), .ADR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .regwrite(regwrite), .dst_adr(dst_adr),
        .write_data(write_data), .read_adr1(read_adr1), .read_adr2(read_adr2),
        .readout1(readout1), .readout2(readout2), .busy_set(busy_set),
        .busy_adr(busy_adr), .stall(stall), .busy_vec(busy_vec)
    );

    register_file_mips #(.DATA_W(16), .NUM_REGS(8), .ADR_W(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .regwrite(s_regwrite), .dst_adr(s_dst_adr),
        .write_data(s_write_data), .read_adr1(s_read_adr1),
        .read_adr2(s_read_adr2), .readout1(s_readout1), .readout2(s_readout2),
        .busy_set(s_busy_set), .busy_adr(s_busy_adr), .stall(s_stall),
        .busy_vec(s_busy_vec)
    );

    typedef struct {
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
        logic          st;
        logic [NR-1:0] bv;
    } exp_t;

    typedef struct {
        logic [15:0] r1;
        logic [15:0] r2;
    } sexp_t;

    exp_t  exp_q[$];
    sexp_t sexp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural register contents and pending flags.
    logic [DW-1:0] m_reg [NR];
    bit            m_busy[NR];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NR; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] adr,
                                                 input bit hit);
        if (adr == 0) return '0;
        if (hit) return write_data;
        return m_reg[adr];
    endfunction

    // Expected outputs for the inputs currently applied.
    function automatic exp_t predict();
        exp_t e;
        bit   wr;
        bit   h1;
        bit   h2;
        e.r1 = '0; e.r2 = '0; e.st = 1'b0; e.bv = '0;
        if (!rst_n) return e;
        wr   = regwrite && (dst_adr != 0);
        h1   = BYPASS && wr && (read_adr1 == dst_adr);
        h2   = BYPASS && wr && (read_adr2 == dst_adr);
        e.r1 = model_read(read_adr1, h1);
        e.r2 = model_read(read_adr2, h2);
        e.st = (m_busy[read_adr1] && !h1) || (m_busy[read_adr2] && !h2);
        for (int i = 0; i < NR; i++) e.bv[i] = m_busy[i];
        return e;
    endfunction

    // State change at a rising edge: completion clears, new producer sets.
    function automatic void model_edge();
        if (!rst_n) return;
        if (regwrite && dst_adr != 0) begin
            m_reg[dst_adr]  = write_data;
            m_busy[dst_adr] = 1'b0;
        end
        if (busy_set && busy_adr != 0) m_busy[busy_adr] = 1'b1;
    endfunction

    // Called at posedge+1: apply inputs, queue prediction, cross the edge.
    task automatic drive(input bit rw, input logic [AW-1:0] dst,
                         input logic [DW-1:0] wd, input logic [AW-1:0] ra1,
                         input logic [AW-1:0] ra2, input bit bs,
                         input logic [AW-1:0] ba);
        regwrite = rw; dst_adr = dst; write_data = wd;
        read_adr1 = ra1; read_adr2 = ra2; busy_set = bs; busy_adr = ba;
        exp_q.push_back(predict());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Reset asserted mid-cycle with write and busy_set active; both ignored.
    task automatic pulse_reset();
        rst_n = 1'b0;
        model_clear();
        regwrite = 1'b1; dst_adr = 5; write_data = 32'hCAFEF00D;
        read_adr1 = 5; read_adr2 = 5; busy_set = 1'b1; busy_adr = 5;
        exp_q.push_back(predict());
        @(posedge clk);
        model_edge();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic s_drive(input bit rw, input logic [2:0] dst,
                           input logic [15:0] wd, input logic [2:0] ra1,
                           input logic [2:0] ra2, input logic [15:0] e1,
                           input logic [15:0] e2);
        sexp_t e;
        s_regwrite = rw; s_dst_adr = dst; s_write_data = wd;
        s_read_adr1 = ra1; s_read_adr2 = ra2;
        e.r1 = e1; e.r2 = e2;
        sexp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare whatever predictions are pending on each falling edge.
    exp_t  mon_e;
    sexp_t mon_s;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("readout1", 64'(readout1), 64'(mon_e.r1));
                check("readout2", 64'(readout2), 64'(mon_e.r2));
                check("stall",    64'(stall),    64'(mon_e.st));
                check("busy_vec", 64'(busy_vec), 64'(mon_e.bv));
            end
            if (sexp_q.size() != 0) begin
                mon_s = sexp_q.pop_front();
                check("small_readout1", 64'(s_readout1), 64'(mon_s.r1));
                check("small_readout2", 64'(s_readout2), 64'(mon_s.r2));
                check("small_stall",    64'(s_stall),    64'd0);
                check("small_busy_vec", 64'(s_busy_vec), 64'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset behaviour: r5 written and visible, then reset mid-cycle.
        drive(1, 5, 32'hDEADBEEF, 0, 0, 1, 6);
        drive(0, 0, 0, 5, 6, 0, 0);
        pulse_reset();
        drive(0, 0, 0, 5, 6, 0, 0);

        // Both ports read the same register; r0 write discarded.
        drive(1, 7, 32'h12345678, 0, 0, 0, 0);
        drive(0, 0, 0, 7, 7, 0, 0);
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Pending flag on r3, stall, then completion clears it.
        drive(0, 0, 0, 0, 0, 1, 3);
        drive(0, 0, 0, 3, 0, 0, 0);
        drive(1, 3, 32'h000000A5, 3, 0, 0, 0);
        drive(0, 0, 0, 3, 3, 0, 0);

        // Set wins over completion on the same register.
        drive(1, 4, 32'h00000055, 4, 0, 1, 4);
        drive(0, 0, 0, 4, 4, 0, 0);

        // Write/bypass on pending r9 while port 2 reads it.
        drive(1, 9, 32'h00000011, 0, 0, 1, 9);
        drive(1, 9, 32'h00000077, 0, 9, 0, 0);
        drive(0, 0, 0, 9, 9, 0, 0);

        // Different-address set and write in one cycle.
        drive(1, 10, 32'h0BADF00D, 0, 0, 1, 11);
        drive(0, 0, 0, 10, 11, 0, 0);

        // Randomized traffic, addresses biased to collide.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(1, 0) == 1,
                  AW'($urandom_range(7, 0)), $urandom,
                  AW'($urandom_range(7, 0)), AW'($urandom_range(NR - 1, 0)),
                  $urandom_range(3, 0) == 0, AW'($urandom_range(7, 0)));
        end
        drive(0, 0, 0, 0, 0, 0, 0);

        // Parameter sweep on the small instance.
        for (int i = 1; i < 8; i++) begin
            s_drive(1, 3'(i), 16'(i * 16'h1111), 0, 0, 16'h0, 16'h0);
        end
        s_drive(1, 0, 16'hFFFF, 0, 0, 16'h0, 16'h0);
        for (int i = 1; i < 8; i++) begin
            s_drive(0, 0, 0, 3'(i), 3'(8 - i),
                    16'(i * 16'h1111), 16'((8 - i) * 16'h1111));
        end
        s_drive(0, 0, 0, 0, 0, 16'h0, 16'h0);

        // Let the monitor drain; leftovers mean a lost comparison.
        for (int w = 0; w < 4 && (exp_q.size() + sexp_q.size()) != 0; w++) begin
            @(negedge clk);
            #1;
        end
        check("queue_drained", 64'(exp_q.size() + sexp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file_mips.md
REGISTER_FILE_MIPS -- requirements
Module: register_file_mips

Interface
- REQ-001: Parameter DATA_W, 32, data width of each register.
- REQ-002: Parameter NUM_REGS, 32, register count; power of two, >= 2.
- REQ-003: Parameter ADR_W, 5, address width; SHALL equal log2(NUM_REGS).
- REQ-004: clk  input  1  single clock; all state updates on rising edge.
- REQ-005: rst_n  input  1  asynchronous, active-low reset.
- REQ-006: regwrite  input  1  write enable for dst_adr/write_data.
- REQ-007: dst_adr  input  ADR_W  write address.
- REQ-008: write_data  input  DATA_W  write data.
- REQ-009: read_adr1, read_adr2  input  ADR_W  read addresses, ports 1 and 2.
- REQ-010: readout1, readout2  output  DATA_W  combinational read data, ports 1 and 2.
- REQ-011: busy_set  input  1  marks busy_adr as pending (outstanding producer).
- REQ-012: busy_adr  input  ADR_W  register to mark pending.
- REQ-013: stall  output  1  high when any read port addresses a pending register.
- REQ-014: busy_vec  output  NUM_REGS  per-register pending flags; bit i = register i.

Function
- REQ-015: Register 0 SHALL read as all-zero at all times; writes to address 0 SHALL be discarded.
- REQ-016: On rising clk edge with regwrite=1 and dst_adr!=0, register[dst_adr] SHALL take write_data.
- REQ-017: readout1/readout2 SHALL be combinational from the register array; a write becomes visible one cycle after the write edge (bypass excepted, REQ-026).
- REQ-018: Both read ports SHALL be independent; identical addresses return identical data.
- REQ-019: On rising edge with busy_set=1 and busy_adr!=0, busy_vec[busy_adr] SHALL set to 1.
- REQ-020: On rising edge with regwrite=1 and dst_adr!=0, busy_vec[dst_adr] SHALL clear to 0.
- REQ-021: busy_set and regwrite to the same address in the same cycle: set wins; the flag SHALL remain/become 1 (a new producer supersedes the completing one).
- REQ-022: busy_set and regwrite to different addresses in the same cycle: both updates SHALL apply.
- REQ-023: busy_vec[0] SHALL be constant 0.
- REQ-024: stall SHALL equal (busy_vec[read_adr1] & ~hit1) | (busy_vec[read_adr2] & ~hit2), where hitN = 0 without bypass, per REQ-026 with bypass.
- REQ-025: stall and busy_vec SHALL be combinational from current state and inputs; no added latency.

Configuration
- REQ-026: Macro REGFILE_BYPASS_EN defined: when regwrite=1, dst_adr!=0 and read_adrN==dst_adr, readoutN SHALL equal write_data in the same cycle, and hitN=1.
- REQ-027: REGFILE_BYPASS_EN undefined: readoutN SHALL return the pre-write register value in the write cycle, and hitN SHALL be 0.

Reset
- REQ-028: rst_n low SHALL immediately, without clk, clear all registers and all busy_vec bits to 0.
- REQ-029: While rst_n is low, readout1, readout2, stall and busy_vec SHALL all be 0, and regwrite/busy_set SHALL be ignored.
- REQ-030: A write or busy_set coincident with the rst_n deassertion edge SHALL be lost; the first effective update is the first rising clk edge after rst_n is high.

Verification
- REQ-031: Reset: write 0xDEADBEEF to r5, pulse rst_n low mid-cycle -> readout1(r5)=0 immediately, busy_vec=0.
- REQ-032: Write r7=0x12345678, then read both ports at r7 next cycle -> readout1=readout2=0x12345678; write r0=0xFFFFFFFF -> r0 reads 0.
- REQ-033: busy_set r3 -> busy_vec[3]=1; read_adr1=3 -> stall=1; regwrite r3=0xA5 -> busy_vec[3]=0, stall=0 next cycle.
- REQ-034: Same cycle busy_set r4 and regwrite r4=0x55 -> r4=0x55 and busy_vec[4]=1 after edge.
- REQ-035: Bypass build: r9 pending, regwrite r9=0x77 with read_adr2=9 -> readout2=0x77 and stall=0 that cycle; non-bypass build -> readout2=old value, stall=1.
- REQ-036: Parameter sweep DATA_W=16, NUM_REGS=8, ADR_W=3: write all r1..r7 with index*0x1111, read back each -> exact match; r0=0.
